// File: rtl/obi_timer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : obi_timer_pkg                                                 |
// | Purpose  : Shared definitions for the OBI machine-timer responder:       |
// |            register offsets, CTRL bit indices, response record, LFSR     |
// |            constants and a byte-enable merge helper.                     |
// | Optional : OBI_TIMER_RAND_STALL_EN uses LFSR_SEED / LFSR_TAPS.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package obi_timer_pkg;

  localparam logic [4:0] MTIME_LO_OFS    = 5'h00;
  localparam logic [4:0] MTIME_HI_OFS    = 5'h04;
  localparam logic [4:0] MTIMECMP_LO_OFS = 5'h08;
  localparam logic [4:0] MTIMECMP_HI_OFS = 5'h0C;
  localparam logic [4:0] CTRL_OFS        = 5'h10;
  localparam logic [4:0] PRESCALE_OFS    = 5'h14;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  // Fibonacci LFSR, taps 16,14,13,11 mapped onto bits [15],[13],[12],[10].
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'b1011_0100_0000_0000;

  // Replace only the bytes of old_w selected by be.
  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/obi_resp_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : obi_resp_pipe                                                 |
// | Purpose  : DEPTH-stage shift register of OBI responses, async clear.     |
// | Ports    : clk_i, rst_ni (async active-low), resp_i (stage 0 input),     |
// |            resp_o (last stage output).                                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module obi_resp_pipe
  import obi_timer_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  resp_t resp_i,
  output resp_t resp_o
);

  resp_t stage_q [DEPTH];
  resp_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = resp_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign resp_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/obi_timer_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : obi_timer_responder                                           |
// | Purpose  : OBI data-port responder with a 64-bit machine timer, compare  |
// |            interrupt and prescaler, in a 32-byte window at BASE_ADDR.    |
// | Ports    : clk_i, rst_ni (async active-low)                              |
// |            req_i/gnt_o/addr_i/we_i/be_i/wdata_i  OBI request channel     |
// |            rvalid_o/rdata_o/err_o                OBI response channel    |
// |            irq_timer_o                           level timer interrupt   |
// | Optional : OBI_TIMER_RAND_STALL_EN -- LFSR-driven random grant stalls.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module obi_timer_responder
  import obi_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1500_0000,
  parameter int          RESP_LATENCY = 1,
  parameter logic [15:0] PRESCALE_RST = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        irq_timer_o
);

  if (RESP_LATENCY < 1 || RESP_LATENCY > 4) begin : g_bad_latency
    $error("obi_timer_responder: RESP_LATENCY must be 1..4");
  end

  // ---------------- grant ----------------
`ifdef OBI_TIMER_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign gnt_o = rst_ni & req_i & ~lfsr_q[0];
`else
  assign gnt_o = rst_ni & req_i;
`endif

  // ---------------- state ----------------
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        irq_q, irq_d;

  // ---------------- decode ----------------
  logic [31:0] offset;
  logic [4:0]  reg_ofs;
  logic        addr_err;
  logic        transfer;
  logic        wr_en;
  logic [31:0] rd_word;
  logic [31:0] wr_word;

  // Addresses below the base wrap to a huge offset and fall out of range.
  assign offset   = addr_i - BASE_ADDR;
  assign reg_ofs  = offset[4:0];
  assign addr_err = (offset[31:5] != '0) || (addr_i[1:0] != 2'b00);
  assign transfer = req_i & gnt_o;
  assign wr_en    = transfer & we_i & ~addr_err;

  always_comb begin
    rd_word = '0;
    case (reg_ofs)
      MTIME_LO_OFS:    rd_word = mtime_q[31:0];
      MTIME_HI_OFS:    rd_word = mtime_q[63:32];
      MTIMECMP_LO_OFS: rd_word = mtimecmp_q[31:0];
      MTIMECMP_HI_OFS: rd_word = mtimecmp_q[63:32];
      CTRL_OFS:        rd_word = {30'b0, ctrl_q};
      PRESCALE_OFS:    rd_word = {16'b0, prescale_q};
      default:         rd_word = '0;
    endcase
  end

  // Merging against the read view keeps unimplemented bits at zero.
  assign wr_word = be_merge(rd_word, wdata_i, be_i);

  // ---------------- next state ----------------
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;

    if (ctrl_q[CTRL_EN_BIT]) begin
      if (pcnt_q == prescale_q) begin
        pcnt_d  = '0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        pcnt_d  = pcnt_q + 16'd1;
      end
    end

    // A bus write to either MTIME half overrides the increment entirely:
    // the other half and unwritten bytes keep their pre-increment value.
    if (wr_en) begin
      case (reg_ofs)
        MTIME_LO_OFS:    mtime_d    = {mtime_q[63:32], wr_word};
        MTIME_HI_OFS:    mtime_d    = {wr_word, mtime_q[31:0]};
        MTIMECMP_LO_OFS: mtimecmp_d = {mtimecmp_q[63:32], wr_word};
        MTIMECMP_HI_OFS: mtimecmp_d = {wr_word, mtimecmp_q[31:0]};
        CTRL_OFS:        ctrl_d     = wr_word[1:0];
        PRESCALE_OFS: begin
          prescale_d = wr_word[15:0];
          pcnt_d     = '0;
        end
        default: ;
      endcase
    end
  end

  assign irq_d = ctrl_q[CTRL_IRQ_EN_BIT] & (mtime_q >= mtimecmp_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      ctrl_q     <= '0;
      prescale_q <= PRESCALE_RST;
      pcnt_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_timer_o = irq_q;

  // ---------------- response ----------------
  resp_t resp_in;
  resp_t resp_out;

  always_comb begin
    resp_in.valid = transfer;
    resp_in.err   = addr_err;
    resp_in.rdata = (addr_err || we_i) ? 32'h0 : rd_word;
  end

  obi_resp_pipe #(
    .DEPTH (RESP_LATENCY)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .resp_i (resp_in),
    .resp_o (resp_out)
  );

  assign rvalid_o = resp_out.valid;
  assign err_o    = resp_out.err;
  assign rdata_o  = resp_out.rdata;

endmodule
`default_nettype wire

// File: tb/tb_obi_timer_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_obi_timer_responder                                        |
// | Purpose  : Self-checking bench for obi_timer_responder (RESP_LATENCY=3). |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_obi_timer_responder;

  localparam int          RL   = 3;
  localparam logic [31:0] BASE = 32'h1500_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        gnt_o, rvalid_o, err_o, irq_timer_o;
  logic [31:0] rdata_o;

  always #5 clk = ~clk;

  obi_timer_responder #(
    .BASE_ADDR    (BASE),
    .RESP_LATENCY (RL),
    .PRESCALE_RST (16'h0000)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .gnt_o       (gnt_o),
    .addr_i      (addr),
    .we_i        (we),
    .be_i        (be),
    .wdata_i     (wdata),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .irq_timer_o (irq_timer_o)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        chk;
    int          exp_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] ofs;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        xerr;
    logic [31:0] xr;
  } vec_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stale = 0;
  logic [31:0] last_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every response must arrive exactly on its expected cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (sbq.size() > 0 && cyc > sbq[0].exp_cyc) begin
        checks++; errors++;
        $display("FAIL missing_resp cyc=%0d expected_at=%0d", cyc, sbq[0].exp_cyc);
        void'(sbq.pop_front());
      end
      if (rvalid_o) begin
        last_rdata = rdata_o;
        if (sbq.size() == 0) begin
          stale++; checks++; errors++;
          $display("FAIL unexpected_resp cyc=%0d rdata=%h err=%b", cyc, rdata_o, err_o);
        end else begin
          e = sbq.pop_front();
          checks++;
          if (cyc != e.exp_cyc || err_o !== e.err || (e.chk && rdata_o !== e.rdata)) begin
            errors++;
            $display("FAIL resp cyc=%0d/%0d err=%b/%b rdata=%h/%h (actual/required)",
                     cyc, e.exp_cyc, err_o, e.err, rdata_o, e.rdata);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req_v);
    end
  endtask

  // Drive one request, hold it until granted, queue the expected response.
  task automatic bus(input logic [31:0] a, input logic w, input logic [3:0] b,
                     input logic [31:0] d, input logic xerr, input logic [31:0] xr,
                     input logic chk);
    bit g;
    g = 1'b0;
    @(negedge clk);
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    for (int n = 0; n < 64; n++) begin
      #1;
      if (gnt_o) begin g = 1'b1; break; end
      @(negedge clk);
    end
    if (!g) begin
      checks++; errors++;
      $display("FAIL grant_timeout addr=%h", a);
      req = 1'b0;
    end else begin
      sbq.push_back('{xerr, xr, chk, cyc + RL});
      @(posedge clk);
      #1 req = 1'b0;
    end
  endtask

  task automatic wr(input logic [31:0] ofs, input logic [31:0] d);
    bus(BASE + ofs, 1'b1, 4'hF, d, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic rd(input logic [31:0] ofs, input logic [31:0] x);
    bus(BASE + ofs, 1'b0, 4'hF, 32'h0, 1'b0, x, 1'b1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench timeout");
  end

  vec_t vt[18];

  initial begin : main
    vt[0]  = '{32'h08, 1'b0, 4'hF, 32'h0,         1'b0, 32'hFFFF_FFFF};
    vt[1]  = '{32'h0C, 1'b0, 4'hF, 32'h0,         1'b0, 32'hFFFF_FFFF};
    vt[2]  = '{32'h10, 1'b0, 4'hF, 32'h0,         1'b0, 32'h0};
    vt[3]  = '{32'h00, 1'b0, 4'hF, 32'h0,         1'b0, 32'h0};
    vt[4]  = '{32'h04, 1'b0, 4'hF, 32'h0,         1'b0, 32'h0};
    vt[5]  = '{32'h14, 1'b0, 4'hF, 32'h0,         1'b0, 32'h0};
    vt[6]  = '{32'h14, 1'b1, 4'b0010, 32'hAABB_CCDD, 1'b0, 32'h0};
    vt[7]  = '{32'h14, 1'b0, 4'hF, 32'h0,         1'b0, 32'h0000_CC00};
    vt[8]  = '{32'h20, 1'b0, 4'hF, 32'h0,         1'b1, 32'h0};
    vt[9]  = '{32'h02, 1'b0, 4'hF, 32'h0,         1'b1, 32'h0};
    vt[10] = '{32'h20, 1'b1, 4'hF, 32'h1234_5678, 1'b1, 32'h0};
    vt[11] = '{32'h18, 1'b0, 4'hF, 32'h0,         1'b0, 32'h0};
    vt[12] = '{32'h1C, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[13] = '{32'h10, 1'b1, 4'h0, 32'h3,         1'b0, 32'h0};
    vt[14] = '{32'h10, 1'b0, 4'hF, 32'h0,         1'b0, 32'h0};
    vt[15] = '{32'h0C, 1'b1, 4'b1000, 32'h1200_0000, 1'b0, 32'h0};
    vt[16] = '{32'h0C, 1'b0, 4'hF, 32'h0,         1'b0, 32'h12FF_FFFF};
    vt[17] = '{32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0,  1'b1, 32'h0};

    // Reset state with a request pending.
    req = 1'b1;
    #12;
    check("rst_gnt",    {63'b0, gnt_o},       64'd0);
    check("rst_rvalid", {63'b0, rvalid_o},    64'd0);
    check("rst_irq",    {63'b0, irq_timer_o}, 64'd0);
    check("rst_rdata",  {32'b0, rdata_o},     64'd0);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b1;

    // Table: reset values, byte writes, reserved and error accesses.
    for (int i = 0; i < 18; i++) begin
      bus(BASE + vt[i].ofs, vt[i].we, vt[i].be, vt[i].wdata,
          vt[i].xerr, vt[i].xr, 1'b1);
    end
    drain();

    // Prescaled counting: PRESCALE=3 -> one tick per 4 cycles.
    wr(32'h14, 32'd3);
    wr(32'h10, 32'd1);
    repeat (40) @(posedge clk);
    bus(BASE + 32'h00, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
    drain();
    checks++;
    if (last_rdata < 32'd9 || last_rdata > 32'd11) begin
      errors++;
      $display("FAIL prescale_count actual=%0d required=10+-1", last_rdata);
    end
    rd(32'h04, 32'h0);
    wr(32'h10, 32'd0);

    // Carry from MTIME_LO into MTIME_HI.
    wr(32'h00, 32'hFFFF_FFFF);
    wr(32'h04, 32'h0);
    wr(32'h14, 32'h0);
    wr(32'h10, 32'd1);
    repeat (4) @(posedge clk);
    wr(32'h10, 32'd0);
    rd(32'h04, 32'h1);
    drain();

    // Compare interrupt timing.
    wr(32'h00, 32'h0);
    wr(32'h04, 32'h0);
    wr(32'h0C, 32'h0);
    wr(32'h08, 32'd20);
    wr(32'h10, 32'd3);
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      if (k == 0)  check("irq_start", {63'b0, irq_timer_o}, 64'd0);
      if (k == 20) check("irq_pre",   {63'b0, irq_timer_o}, 64'd0);
      if (k == 21) check("irq_rise",  {63'b0, irq_timer_o}, 64'd1);
    end
    wr(32'h08, 32'd1000);
    @(negedge clk);
    check("irq_hold", {63'b0, irq_timer_o}, 64'd1);
    @(negedge clk);
    check("irq_fall", {63'b0, irq_timer_o}, 64'd0);
    wr(32'h10, 32'd0);
    drain();

    // Back-to-back reads: each response checked on its exact cycle.
    rd(32'h08, 32'd1000);
    rd(32'h0C, 32'h0);
    rd(32'h10, 32'h0);
    rd(32'h14, 32'h0);
    drain();

    // Reset with responses in flight.
    rd(32'h08, 32'd1000);
    rd(32'h0C, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rvalid", {63'b0, rvalid_o}, 64'd0);
    sbq.delete();
    stale = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_stale", 64'(stale), 64'd0);
    rd(32'h08, 32'hFFFF_FFFF);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
